// File: rtl/stream_gk_pkg.sv
// Shared types for the stream gatekeeper: FSM states, per-beat flags,
// per-cycle frame events and the channel-select clamp.
package stream_gk_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PASS = 3'd1,
    PAD  = 3'd2,
    TERM = 3'd3,
    DROP = 3'd4
  } gk_state_e;

  // Width-independent part of a beat; the data/empty fields depend on module
  // parameters, so gk_beat_t is completed inside the top module.
  typedef struct packed {
    logic sop;
    logic eop;
    logic err;
    logic valid;
  } gk_flags_t;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_OK     = 3'd1,
    EV_SHORT  = 3'd2,
    EV_LONG   = 3'd3,
    EV_BB     = 3'd4,
    EV_ORPHAN = 3'd5
  } gk_event_e;

  function automatic int unsigned clamp_sel(input int unsigned s, input int unsigned n);
    return (s >= n) ? 0 : s;
  endfunction

endpackage

// File: rtl/stream_gk_mux.sv
// Combinational NUM_CH:1 beat selector; picks the lanes of channel i_ch.
module stream_gk_mux
  import stream_gk_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int SEL_W   = $clog2(NUM_CH)
) (
  input  logic [SEL_W-1:0]          i_ch,
  input  logic [NUM_CH*DATA_W-1:0]  i_data,
  input  logic [NUM_CH*EMPTY_W-1:0] i_empty,
  input  logic [NUM_CH-1:0]         i_sop,
  input  logic [NUM_CH-1:0]         i_eop,
  input  logic [NUM_CH-1:0]         i_err,
  input  logic [NUM_CH-1:0]         i_valid,
  output logic [DATA_W-1:0]         o_data,
  output logic [EMPTY_W-1:0]        o_empty,
  output gk_flags_t                 o_flags
);

  always_comb begin
    o_data  = '0;
    o_empty = '0;
    o_flags = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_ch == c[SEL_W-1:0]) begin
        o_data        = i_data[c*DATA_W +: DATA_W];
        o_empty       = i_empty[c*EMPTY_W +: EMPTY_W];
        o_flags.sop   = i_sop[c];
        o_flags.eop   = i_eop[c];
        o_flags.err   = i_err[c];
        o_flags.valid = i_valid[c];
      end
    end
  end

endmodule

// File: rtl/stream_gatekeeper.sv
// N-channel frame gatekeeper: one registered output stream with length and
// framing repair. Optional counters under `STREAM_GK_STATS_EN.
module stream_gatekeeper
  import stream_gk_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int MIN_BEATS = 2,
  parameter int MAX_BEATS = 272,
  parameter int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                      iCLK_CORE,
  input  logic                      iRST_LINK_FC_CORE,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_CH*DATA_W-1:0]  in_data,
  input  logic [NUM_CH*EMPTY_W-1:0] in_empty,
  input  logic [NUM_CH-1:0]         in_sop,
  input  logic [NUM_CH-1:0]         in_eop,
  input  logic [NUM_CH-1:0]         in_err,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      out_err,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          act_ch,
`ifdef STREAM_GK_STATS_EN
  output logic [31:0]               frames_ok,
  output logic [31:0]               frames_short,
  output logic [31:0]               frames_long,
  output logic [31:0]               frames_bb,
  output logic [31:0]               orphan_eop,
`endif
  output logic                      viol_pulse
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MIN    = CNT_W'(MIN_BEATS);
  localparam logic [CNT_W-1:0] C_MIN_M1 = CNT_W'(MIN_BEATS - 1);
  localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] C_MAX_M1 = CNT_W'(MAX_BEATS - 1);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [EMPTY_W-1:0] empty;
    gk_flags_t          f;
  } gk_beat_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == C_MAX) ? v : v + C_ONE;
  endfunction

  // A repaired frame pads with zero beats until only the terminator is left.
  function automatic gk_state_e repair_state(input logic [CNT_W-1:0] n);
    return (n >= C_MIN_M1) ? TERM : PAD;
  endfunction

  gk_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_bcnt, w_bcnt_nxt, w_binc;
  logic [SEL_W-1:0]   w_sel_cl, w_ch;
  logic [DATA_W-1:0]  w_in_data;
  logic [EMPTY_W-1:0] w_in_empty;
  gk_flags_t          w_in;
  gk_beat_t           w_beat;
  gk_event_e          w_cause;
  logic               w_viol;

  // Channel ownership only moves while idle, so sel is ignored mid-frame.
  assign w_sel_cl = SEL_W'(clamp_sel(32'(sel), NUM_CH));
  assign w_ch     = (r_state == IDLE) ? w_sel_cl : act_ch;
  assign w_binc   = sat_inc(r_bcnt);
  assign w_viol   = (w_cause != EV_NONE) && (w_cause != EV_OK);

  stream_gk_mux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .EMPTY_W(EMPTY_W),
    .SEL_W  (SEL_W)
  ) u_mux (
    .i_ch   (w_ch),
    .i_data (in_data),
    .i_empty(in_empty),
    .i_sop  (in_sop),
    .i_eop  (in_eop),
    .i_err  (in_err),
    .i_valid(in_valid),
    .o_data (w_in_data),
    .o_empty(w_in_empty),
    .o_flags(w_in)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_beat      = '0;
    w_cause     = EV_NONE;
    case (r_state)
      IDLE: begin
        w_bcnt_nxt = '0;
        if (w_in.valid && w_in.sop) begin
          w_beat.data    = w_in_data;
          w_beat.empty   = w_in_empty;
          w_beat.f.sop   = 1'b1;
          w_beat.f.valid = 1'b1;
          w_bcnt_nxt     = C_ONE;
          if (w_in.eop) begin
            w_cause     = EV_SHORT;
            w_state_nxt = repair_state(C_ONE);
          end else begin
            w_beat.f.err = w_in.err;
            w_state_nxt  = PASS;
          end
        end else if (w_in.valid && w_in.eop) begin
          w_cause = EV_ORPHAN;
        end
      end
      PASS: begin
        if (w_in.valid) begin
          w_bcnt_nxt     = w_binc;
          w_beat.f.valid = 1'b1;
          if (w_in.sop) begin
            // A new frame started before this one ended: close with an error
            // beat and skip the intruder; a one-beat intruder is already over.
            w_beat.f.eop = 1'b1;
            w_beat.f.err = 1'b1;
            w_cause      = EV_BB;
            w_state_nxt  = w_in.eop ? IDLE : DROP;
          end else begin
            w_beat.data  = w_in_data;
            w_beat.empty = w_in_empty;
            if (w_in.eop && (w_binc >= C_MIN)) begin
              w_beat.f.eop = 1'b1;
              w_beat.f.err = w_in.err;
              w_cause      = EV_OK;
              w_state_nxt  = IDLE;
            end else if (w_in.eop) begin
              w_cause     = EV_SHORT;
              w_state_nxt = repair_state(w_binc);
            end else if (r_bcnt == C_MAX_M1) begin
              w_beat.f.eop = 1'b1;
              w_beat.f.err = 1'b1;
              w_cause      = EV_LONG;
              w_state_nxt  = DROP;
            end else begin
              w_beat.f.err = w_in.err;
            end
          end
        end
      end
      PAD: begin
        w_beat.f.valid = 1'b1;
        w_bcnt_nxt     = w_binc;
        w_state_nxt    = repair_state(w_binc);
      end
      TERM: begin
        w_beat.f.valid = 1'b1;
        w_beat.f.eop   = 1'b1;
        w_beat.f.err   = 1'b1;
        w_bcnt_nxt     = w_binc;
        w_state_nxt    = IDLE;
      end
      DROP: begin
        if (w_in.valid && w_in.eop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output register stage: data holds its last value across idle cycles.
  always_ff @(posedge iCLK_CORE) begin
    if (iRST_LINK_FC_CORE) begin
      r_state    <= IDLE;
      r_bcnt     <= '0;
      act_ch     <= '0;
      out_data   <= '0;
      out_empty  <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
      viol_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bcnt     <= w_bcnt_nxt;
      act_ch     <= w_ch;
      out_sop    <= w_beat.f.sop;
      out_eop    <= w_beat.f.eop;
      out_err    <= w_beat.f.err;
      out_valid  <= w_beat.f.valid;
      viol_pulse <= w_viol;
      if (w_beat.f.valid) begin
        out_data  <= w_beat.data;
        out_empty <= w_beat.empty;
      end
    end
  end

`ifdef STREAM_GK_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge iCLK_CORE) begin
    if (iRST_LINK_FC_CORE) begin
      frames_ok    <= '0;
      frames_short <= '0;
      frames_long  <= '0;
      frames_bb    <= '0;
      orphan_eop   <= '0;
    end else begin
      case (w_cause)
        EV_OK:     frames_ok    <= sat_inc32(frames_ok);
        EV_SHORT:  frames_short <= sat_inc32(frames_short);
        EV_LONG:   frames_long  <= sat_inc32(frames_long);
        EV_BB:     frames_bb    <= sat_inc32(frames_bb);
        EV_ORPHAN: orphan_eop   <= sat_inc32(orphan_eop);
        default:   ;
      endcase
    end
  end
`endif

endmodule
